// File: rtl/ysyx_24100013_ifu.sv
// Instruction fetch unit: owns the PC, keeps one word request to instruction
// memory in flight at a time, buffers each returned word and delivers it to
// decode over a valid/ready handshake. Fetch stops permanently after an
// ebreak or a faulting fetch has been handed to decode.
`timescale 1ns/1ps
module ysyx_24100013_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [1:0]  ST_REQ  = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;
    localparam logic [1:0]  ST_OUT  = 2'd2;
    localparam logic [1:0]  ST_HALT = 2'd3;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    // True when handing this word to decode must end fetching for good.
    function automatic logic stops_fetch(input logic [31:0] word, input logic fault);
        return (word == EBREAK) || fault;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        drop_r;
    logic        drop_nxt_s;
    logic [31:0] inst_r;
    logic [31:0] inst_nxt_s;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_pc_nxt_s;
    logic        inst_fault_r;
    logic        inst_fault_nxt_s;
    logic [31:0] target_s;
    logic        redirect_lsb_unused_s;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign target_s              = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        drop_nxt_s       = drop_r;
        inst_nxt_s       = inst_r;
        inst_pc_nxt_s    = inst_pc_r;
        inst_fault_nxt_s = inst_fault_r;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    // Request is withheld this cycle so the new PC is fetched instead.
                    pc_nxt_s    = target_s;
                    state_nxt_s = ST_REQ;
                end else if (imem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt_s = target_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (imem_rsp_valid) begin
                    drop_nxt_s = 1'b0;
                    if (drop_r || redirect_valid) begin
                        // Response belongs to a path that was redirected away.
                        state_nxt_s = ST_REQ;
                    end else begin
                        inst_nxt_s       = imem_rsp_data;
                        inst_pc_nxt_s    = pc_r;
                        inst_fault_nxt_s = imem_rsp_err;
                        state_nxt_s      = ST_OUT;
                    end
                end else if (redirect_valid) begin
                    // Remember to discard the response that is still on its way.
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = drop_r;
                end
            end
            ST_OUT: begin
                if (inst_ready) begin
                    if (stops_fetch(inst_r, inst_fault_r)) begin
                        state_nxt_s = ST_HALT;
                    end else if (redirect_valid) begin
                        pc_nxt_s    = target_s;
                        state_nxt_s = ST_REQ;
                    end else begin
                        pc_nxt_s    = pc_r + 32'd4;
                        state_nxt_s = ST_REQ;
                    end
                end else if (redirect_valid) begin
                    // Buffered word is on the wrong path; abandon it.
                    pc_nxt_s    = target_s;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // State, PC, drop flag and output buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            drop_r       <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
            inst_fault_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            drop_r       <= drop_nxt_s;
            inst_r       <= inst_nxt_s;
            inst_pc_r    <= inst_pc_nxt_s;
            inst_fault_r <= inst_fault_nxt_s;
        end
    end

    // The request is masked while rst is high so nothing escapes during reset.
    assign imem_req_valid = (state_r == ST_REQ) && !redirect_valid && !rst;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = (state_r == ST_OUT);
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign inst_fault     = inst_fault_r;
    assign halted         = (state_r == ST_HALT);

endmodule

// File: tb/tb_ysyx_24100013_ifu.sv
// Self-checking bench for ysyx_24100013_ifu: a bench-side instruction memory
// with programmable latency, a scoreboard of expected deliveries, a per-cycle
// vector table for the first fetches and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ysyx_24100013_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    ysyx_24100013_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    typedef struct {
        logic        rr;
        logic        ir;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t out_e;
    bit   out_drop = 1'b0;
    bit   mem_pending = 1'b0;
    int   mem_cnt = 0;
    int   mem_lat = 1;
    logic [31:0] mem_addr = 32'd0;
    bit   ebreak_en = 1'b0;
    bit   err_en = 1'b0;
    vec_t vecs[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ebreak_en && a == 32'h8000_000C) return 32'h0010_0073;
        return {a[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return err_en && (a == 32'h8000_0010);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: observe this cycle at the falling edge, then advance memory.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            sb_q.delete();
            mem_pending = 1'b0;
            out_drop    = 1'b0;
        end else begin
            if (inst_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: inst_valid at pc %h, no delivery expected", inst_pc);
                end else if (inst_ready) begin
                    e = sb_q.pop_front();
                    chk("sb_inst", inst, e.data);
                    chk("sb_inst_pc", inst_pc, e.pc);
                    chk("sb_inst_fault", {31'd0, inst_fault}, {31'd0, e.fault});
                end
            end
            if ((mem_pending || imem_rsp_valid) && redirect_valid) out_drop = 1'b1;
            if (imem_rsp_valid) begin
                if (!out_drop) sb_q.push_back(out_e);
                out_drop = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_addr    = imem_req_addr;
                out_e       = '{mem_word(mem_addr), mem_addr, mem_err(mem_addr)};
                out_drop    = 1'b0;
                mem_pending = 1'b1;
                mem_cnt     = mem_lat;
            end
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                imem_rsp_err   = mem_err(mem_addr);
                mem_pending    = 1'b0;
            end
        end
    endtask

    task automatic wait_for_req(input string name, input int budget);
        int n;
        n = 0;
        #1;
        while (!imem_req_valid && n < budget) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (!imem_req_valid) begin
            errors++;
            $display("FAIL %s: imem_req_valid got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_for_inst(input string name, input int budget);
        int n;
        n = 0;
        #1;
        while (!inst_valid && n < budget) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("FAIL %s: inst_valid got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    // Fetch one word at exp_pc and hand it to decode immediately.
    task automatic fetch_one(input string name, input logic [31:0] exp_pc);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        wait_for_req(name, 10);
        chk({name, "_addr"}, imem_req_addr, exp_pc);
        tick();
        imem_req_ready = 1'b0;
        wait_for_inst(name, 10);
        chk({name, "_inst_pc"}, inst_pc, exp_pc);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rr    ir    rv    addr           iv    inst_pc
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0004};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0008};

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset state.
        tick();
        tick();
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_fault", {31'd0, inst_fault}, 32'd0);
        rst = 1'b0;

        // Sequential fetch with a 1-cycle memory, cycle by cycle.
        for (int i = 0; i < 9; i++) begin
            imem_req_ready = vecs[i].rr;
            inst_ready     = vecs[i].ir;
            #1;
            chk($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_iv});
            if (vecs[i].exp_iv) chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_ipc);
            tick();
        end

        // Decode backpressure for 5 cycles on the word at 8000_000C.
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        wait_for_req("bp_req", 5);
        chk("bp_req_addr", imem_req_addr, 32'h8000_000C);
        tick();
        imem_req_ready = 1'b0;
        wait_for_inst("bp_inst", 5);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_inst_valid", i), {31'd0, inst_valid}, 32'd1);
            chk($sformatf("bp%0d_inst", i), inst, mem_word(32'h8000_000C));
            chk($sformatf("bp%0d_inst_pc", i), inst_pc, 32'h8000_000C);
            chk($sformatf("bp%0d_req_valid", i), {31'd0, imem_req_valid}, 32'd0);
            tick();
        end
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        chk("bp_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("bp_next_req_addr", imem_req_addr, 32'h8000_0010);

        // Redirect while waiting on a 3-cycle response: response is dropped.
        mem_lat = 3;
        tick();
        mem_lat        = 1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        #1;
        chk("rdw_w1_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            #1;
            chk($sformatf("rdw_w%0d_inst_valid", i), {31'd0, inst_valid}, 32'd0);
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        chk("rdw_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rdw_req_addr", imem_req_addr, 32'h8000_0100);
        chk("rdw_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Redirect together with inst_ready in OUT: target beats pc + 4.
        tick();
        imem_req_ready = 1'b0;
        wait_for_inst("rdo_inst", 5);
        chk("rdo_inst_pc", inst_pc, 32'h8000_0100);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_000A;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rdo_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rdo_req_addr", imem_req_addr, 32'h8000_0008);

        // ebreak at 8000_000C halts fetch; redirects are then ignored.
        ebreak_en = 1'b1;
        fetch_one("eb8", 32'h8000_0008);
        fetch_one("ebc", 32'h8000_000C);
        #1;
        chk("eb_halted", {31'd0, halted}, 32'd1);
        chk("eb_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("eb_inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("eb_rd%0d_req_valid", i), {31'd0, imem_req_valid}, 32'd0);
            chk($sformatf("eb_rd%0d_halted", i), {31'd0, halted}, 32'd1);
            tick();
        end
        redirect_valid = 1'b0;
        tick();
        #1;
        chk("eb_after_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("eb_after_halted", {31'd0, halted}, 32'd1);

        // Reset from HALT restarts at RESET_PC; then a faulting fetch halts.
        rst = 1'b1;
        tick();
        #1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst2_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst2_inst", inst, 32'd0);
        rst       = 1'b0;
        ebreak_en = 1'b0;
        err_en    = 1'b1;
        fetch_one("f0", 32'h8000_0000);
        fetch_one("f4", 32'h8000_0004);
        fetch_one("f8", 32'h8000_0008);
        fetch_one("fc", 32'h8000_000C);
        fetch_one("ferr", 32'h8000_0010);
        #1;
        chk("err_halted", {31'd0, halted}, 32'd1);
        chk("err_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // Redirect in REQ to the top word, then PC wraps to 0.
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        err_en         = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        chk("wrap_redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        fetch_one("wrap_top", 32'hFFFF_FFFC);
        #1;
        chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
